conv_pool_stream: RTL and testbench



---
 rtl/conv_pkg.sv | 13 +
 rtl/conv_pool_stream_acc.sv | 49 ++++
 rtl/conv_pool_stream.sv | 61 ++++++
 tb/tb_conv_pool_stream.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and sizing for the conv -> pool streaming path.
// Optional macro: CONV_POOL_AVG_EN selects average pooling in pool_window_acc.
package conv_pkg;
    localparam int WIDTH   = 16;
    localparam int LENY    = 32;
    localparam int POOL    = 2;
    localparam int LOGPOOL = 1;
    localparam int CNTW    = 6;

    typedef logic signed [WIDTH-1:0]         sample_t;
    typedef logic signed [WIDTH+LOGPOOL-1:0] acc_t;
    typedef logic [CNTW-1:0]                 cnt_t;
endpackage

// File: rtl/conv_pool_stream_acc.sv
// Window accumulator for the pool stage: running max, or running sum when
// CONV_POOL_AVG_EN is defined. result already includes the current sample.
import conv_pkg::*;

module pool_window_acc (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    update,
    input  logic signed [WIDTH-1:0] sample,
    output logic signed [WIDTH-1:0] result
);
`ifdef CONV_POOL_AVG_EN
    acc_t acc;
    acc_t acc_nxt;

    // Floor division by the window size; partial windows behave zero-padded.
    function automatic sample_t avg_round(input acc_t s);
        return sample_t'(s >>> LOGPOOL);
    endfunction

    always_comb begin
        acc_nxt = load ? acc_t'(sample) : acc + acc_t'(sample);
    end

    assign result = avg_round(acc_nxt);
`else
    sample_t acc;
    sample_t acc_nxt;

    function automatic sample_t max_sel(input sample_t a, input sample_t b);
        return (b > a) ? b : a;
    endfunction

    always_comb begin
        acc_nxt = load ? sample : max_sel(acc, sample);
    end

    assign result = acc_nxt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (update) begin
            acc <= acc_nxt;
        end
    end
endmodule

// File: rtl/conv_pool_stream.sv
// Streaming 1-D pool stage behind the conv engine; one result per window of
// POOL samples, windows aligned to frames. Optional macro: CONV_POOL_AVG_EN.
import conv_pkg::*;

module conv_pool_stream (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] s_data_in_y,
    input  logic                    s_valid_y,
    output logic                    s_ready_y,
    output logic signed [WIDTH-1:0] m_data_out_z,
    output logic                    m_valid_z,
    input  logic                    m_ready_z
);
    cnt_t    win_cnt;
    cnt_t    frm_cnt;
    logic    accept;
    logic    win_last;
    logic    frm_last;
    logic    close;
    sample_t result;

    // A held result stalls the input; a result being taken frees the slot now.
    assign s_ready_y = ~reset & (~m_valid_z | m_ready_z);
    assign accept    = s_valid_y & s_ready_y;
    assign win_last  = (win_cnt == cnt_t'(POOL - 1));
    assign frm_last  = (frm_cnt == cnt_t'(LENY - 1));
    assign close     = accept & (win_last | frm_last);

    pool_window_acc u_acc (
        .clk    (clk),
        .reset  (reset),
        .load   (win_cnt == '0),
        .update (accept),
        .sample (s_data_in_y),
        .result (result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt <= '0;
            frm_cnt <= '0;
        end else if (accept) begin
            win_cnt <= close ? '0 : win_cnt + 1'b1;
            frm_cnt <= frm_last ? '0 : frm_cnt + 1'b1;
        end
    end

    // Output register: a new close overwrites a result accepted at the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_z    <= 1'b0;
            m_data_out_z <= '0;
        end else if (close) begin
            m_valid_z    <= 1'b1;
            m_data_out_z <= result;
        end else if (m_valid_z && m_ready_z) begin
            m_valid_z    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_conv_pool_stream.sv
// Scoreboard bench for conv_pool_stream: random frames, random backpressure.
import conv_pkg::*;

module tb_conv_pool_stream;
    logic                    clk = 1'b0;
    logic                    reset;
    logic signed [WIDTH-1:0] s_data_in_y;
    logic                    s_valid_y;
    logic                    s_ready_y;
    logic signed [WIDTH-1:0] m_data_out_z;
    logic                    m_valid_z;
    logic                    m_ready_z;

    int      n_checks = 0;
    int      n_fail = 0;
    int      n_out = 0;
    int      ready_mode = 1;
    sample_t exp_q[$];
    logic    holding = 1'b0;
    sample_t held_val;

    conv_pool_stream dut (
        .clk          (clk),
        .reset        (reset),
        .s_data_in_y  (s_data_in_y),
        .s_valid_y    (s_valid_y),
        .s_ready_y    (s_ready_y),
        .m_data_out_z (m_data_out_z),
        .m_valid_z    (m_valid_z),
        .m_ready_z    (m_ready_z)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: split the frame into POOL-wide windows, last one may be short.
    function automatic void model_frame(input sample_t y[LENY]);
        for (int lo = 0; lo < LENY; lo += POOL) begin
            int hi = (lo + POOL < LENY) ? lo + POOL : LENY;
`ifdef CONV_POOL_AVG_EN
            int s = 0;
            int q;
            for (int i = lo; i < hi; i++) s += int'(y[i]);
            q = s / POOL;
            if ((s % POOL) != 0 && s < 0) q--;
            exp_q.push_back(sample_t'(q));
`else
            int m = int'(y[lo]);
            for (int i = lo + 1; i < hi; i++) if (int'(y[i]) > m) m = int'(y[i]);
            exp_q.push_back(sample_t'(m));
`endif
        end
    endfunction

    task automatic send_frame(input sample_t y[LENY], input int gap_pct, output int cycles);
        bit acc;
        int t;
        cycles = 0;
        model_frame(y);
        for (int i = 0; i < LENY; i++) begin
            if (gap_pct > 0 && ($urandom % 100) < gap_pct) begin
                s_valid_y = 1'b0;
                @(posedge clk); #1;
                cycles++;
            end
            s_valid_y   = 1'b1;
            s_data_in_y = y[i];
            acc = 1'b0;
            t = 0;
            while (!acc) begin
                @(negedge clk);
                acc = s_ready_y;
                @(posedge clk); #1;
                cycles++;
                t++;
                if (!acc && t > 200) begin
                    check("accept_timeout", 0, 1);
                    break;
                end
            end
        end
        s_valid_y = 1'b0;
    endtask

    task automatic rand_frame(output sample_t y[LENY]);
        for (int i = 0; i < LENY; i++) y[i] = sample_t'($urandom);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || m_valid_z) && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_timeout", longint'(t < 2000), 1);
    endtask

    initial begin
        m_ready_z = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       m_ready_z = (($urandom % 100) < 60);
                1:       m_ready_z = 1'b1;
                default: m_ready_z = 1'b0;
            endcase
        end
    end

    // Monitor: a transfer is due at the next rising edge whenever valid & ready.
    always @(negedge clk) begin
        if (!reset) begin
            check("s_ready", longint'(s_ready_y), longint'(!m_valid_z || m_ready_z));
            if (holding && m_valid_z) check("hold_data", m_data_out_z, held_val);
            holding  = m_valid_z && !m_ready_z;
            held_val = m_data_out_z;
            if (m_valid_z && m_ready_z) begin
                n_out++;
                if (exp_q.size() == 0) check("unexpected_out", m_data_out_z, 0);
                else check("z_data", m_data_out_z, exp_q.pop_front());
            end
        end else begin
            holding = 1'b0;
        end
    end

    initial begin
        sample_t y[LENY];
        int cyc;
        int cyc2;
        int k;
        int out0;

        reset = 1'b1;
        s_valid_y = 1'b0;
        s_data_in_y = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", m_valid_z, 0);
        check("rst_m_data", m_data_out_z, 0);
        check("rst_s_ready", s_ready_y, 0);
        reset = 1'b0;

        // Directed frame with backpressure on the first result.
        rand_frame(y);
        y[0] = 5; y[1] = 9; y[2] = 0; y[3] = 3; y[4] = 7; y[5] = 7;
        y[6] = -300; y[7] = -7; y[8] = -32768; y[9] = 32767;
        ready_mode = 2;
        m_ready_z = 1'b0;
        fork
            send_frame(y, 0, cyc);
            begin
                k = 0;
                while (!m_valid_z && k < 50) begin
                    @(posedge clk); #1;
                    k++;
                end
                check("first_valid_cycle", k, 2);
                repeat (10) begin
                    @(posedge clk); #1;
                    check("bp_s_ready", s_ready_y, 0);
                end
`ifndef CONV_POOL_AVG_EN
                check("bp_hold_value", m_data_out_z, 9);
`endif
                ready_mode = 1;
            end
        join
        wait_drain();

        // Random frames under random gaps and random backpressure.
        ready_mode = 0;
        repeat (4) begin
            rand_frame(y);
            send_frame(y, 30, cyc);
        end
        ready_mode = 1;
        wait_drain();

        // Back-to-back frames at full rate.
        @(posedge clk); #1;
        out0 = n_out;
        rand_frame(y);
        send_frame(y, 0, cyc);
        rand_frame(y);
        send_frame(y, 0, cyc2);
        check("full_rate_cycles", cyc + cyc2, 2 * LENY);
        wait_drain();
        check("full_rate_outputs", n_out - out0, 2 * ((LENY + POOL - 1) / POOL));

        // Reset with a partial window in flight.
        s_valid_y = 1'b1;
        s_data_in_y = 12;
        @(posedge clk); #1;
        s_valid_y = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_m_valid", m_valid_z, 0);
        check("midrst_m_data", m_data_out_z, 0);
        reset = 1'b0;
        rand_frame(y);
        y[0] = 4; y[1] = 6;
        ready_mode = 0;
        send_frame(y, 20, cyc);
        ready_mode = 1;
        wait_drain();

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
